// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses a 4-bit ripple-carry stage,
// processing one nibble per clock from the LSB up and reporting carry and signed overflow.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / 4;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               carry;
    logic [IDX_W-1:0]   idx;

    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [4:0]         nib_sum;
    logic               last_nib;
    logic [IDX_W+1:0]   bit_pos;

    // 4-bit ripple-carry stage fed by the currently selected operand nibbles
    always_comb begin
        bit_pos  = {idx, 2'b00};
        nib_a    = 4'(op_a >> bit_pos);
        nib_b    = 4'(op_b >> bit_pos);
        nib_sum  = 5'(nib_a) + 5'(nib_b) + 5'(carry);
        last_nib = (idx == IDX_W'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    sum   <= (sum & ~(WIDTH'(4'hF) << bit_pos))
                           | (WIDTH'(nib_sum[3:0]) << bit_pos);
                    carry <= nib_sum[4];
                    idx   <= idx + IDX_W'(1);
                    if (last_nib) begin
                        c_out    <= nib_sum[4];
                        overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1])
                                 && (nib_sum[3] != op_a[WIDTH-1]);
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation; start in RUN is dropped
                    if (start) begin
                        op_a     <= a;
                        op_b     <= b;
                        carry    <= c_in;
                        idx      <= '0;
                        sum      <= '0;
                        c_out    <= 1'b0;
                        overflow <= 1'b0;
                        state    <= RUN;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16): directed corner cases plus
// randomized operations checked against a plain-arithmetic reference.
module tb_nibble_serial_adder;

    localparam int unsigned W = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    typedef struct {
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   passes = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t e;
        logic [W:0] full;
        full    = (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
        e.sum   = full[W-1:0];
        e.c_out = full[W];
        e.ovf   = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("c_out", 32'(c_out), 32'(e.c_out));
                check("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    // Issues one operation at the current cycle; returns #1 after the edge that raised done
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input bit scramble);
        int n;
        int busy_cycles;
        a     = ta;
        b     = tb_;
        c_in  = tc;
        start = 1'b1;
        @(posedge clk); #1;
        last_exp = model(ta, tb_, tc);
        sb.push_back(last_exp);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        n = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) busy_cycles++;
            if (scramble) begin
                a     = W'($urandom);
                b     = W'($urandom);
                c_in  = 1'($urandom);
                start = (n == 1);
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("done_latency", 32'(n), 32'd5);
        check("busy_cycles", 32'(busy_cycles), 32'd4);
    endtask

    // After done with no new start: block goes idle, result held, no further done
    task automatic idle_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check("hold_done", 32'(done), 32'd0);
            check("hold_busy", 32'(busy), 32'd0);
            check("hold_sum", 32'(sum), 32'(last_exp.sum));
            check("hold_c_out", 32'(c_out), 32'(last_exp.c_out));
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_sum"}, 32'(sum), 32'd0);
        check({name, "_c_out"}, 32'(c_out), 32'd0);
        check({name, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        idle_hold(2);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle_hold(1);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        idle_hold(1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        idle_hold(1);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        idle_hold(1);

        // Start ignored during RUN, operands scrambled, then back-to-back start in done cycle
        run_op(16'h0001, 16'h0001, 1'b0, 1'b1);
        run_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        idle_hold(2);

        // Reset on the second RUN cycle aborts the operation
        a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("abort");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        idle_hold(1);

        // Reset dominates start
        reset = 1'b1;
        start = 1'b1;
        a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_all_zero("reset_start");
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        // Randomized operations, mixing back-to-back and idle gaps
        for (int i = 0; i < 30; i++) begin
            logic [3:0] pick;
            logic [W-1:0] ra, rb;
            pick = 4'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            if (pick[1:0] == 2'd0) ra = 16'hFFFF;
            if (pick[3:2] == 2'd0) rb = 16'h8000;
            run_op(ra, rb, 1'($urandom), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_hold(1);
        end
        idle_hold(2);

        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
